// File: rtl/multi_event_sampler.sv
// Multi-channel sliding-window sampler: freezes PRE pre-trigger samples, the trigger sample and the post samples.
// Latency WINDOW-PRE-1 edges from trigger to event_valid; Ch never stalls, a held event blocks triggers until event_saved.
module multi_event_sampler #(
  parameter int N_CH   = 16,
  parameter int SAMP_W = 2,
  parameter int WINDOW = 32,
  parameter int PRE    = 8,
  parameter int CNT_W  = 16
) (
  input  logic                                  clk_500,
  input  logic                                  reset,
  input  logic [N_CH-1:0][SAMP_W-1:0]           Ch,
  input  logic                                  trigger,
  input  logic                                  event_saved,
  output logic [N_CH-1:0][WINDOW*SAMP_W-1:0]    evento,
  output logic                                  event_valid,
  output logic                                  armed,
  output logic [CNT_W-1:0]                      trig_count,
  output logic [CNT_W-1:0]                      lost_count
);
  localparam int WIN_W  = WINDOW * SAMP_W;
  localparam int POST_N = WINDOW - PRE - 1;
  localparam int CW     = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {FILL, ARMED, POST, HOLD} state_t;

  state_t                     state, state_nxt;
  logic [N_CH-1:0][WIN_W-1:0] win, win_nxt;
  logic                       trig_d;
  logic                       trig_edge;
  logic [CW-1:0]              fill_cnt, fill_cnt_nxt;
  logic [CW-1:0]              post_cnt, post_cnt_nxt;
  logic                       capture;
  logic                       lost;

  assign trig_edge = trigger & ~trig_d;
  assign lost      = trig_edge & (state != ARMED);

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      win_nxt[c] = {win[c][WIN_W-SAMP_W-1:0], Ch[c]};
    end
  end

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    post_cnt_nxt = post_cnt;
    capture      = 1'b0;
    case (state)
      FILL: begin
        fill_cnt_nxt = fill_cnt + CW'(1);
        if (fill_cnt == CW'(PRE - 1)) state_nxt = ARMED;
      end
      ARMED: begin
        if (trig_edge) begin
          // With no post samples the trigger sample itself completes the window.
          if (POST_N == 0) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end else begin
            post_cnt_nxt = CW'(POST_N);
            state_nxt    = POST;
          end
        end
      end
      POST: begin
        post_cnt_nxt = post_cnt - CW'(1);
        if (post_cnt == CW'(1)) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (event_saved) state_nxt = ARMED;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk_500) begin
    if (!reset) begin
      state       <= FILL;
      fill_cnt    <= '0;
      post_cnt    <= '0;
      win         <= '0;
      trig_d      <= 1'b0;
      evento      <= '0;
      event_valid <= 1'b0;
      armed       <= 1'b0;
      trig_count  <= '0;
      lost_count  <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
      post_cnt <= post_cnt_nxt;
      win      <= win_nxt;
      trig_d   <= trigger;
      armed    <= (state_nxt == ARMED);
      if (capture) begin
        evento      <= win_nxt;
        event_valid <= 1'b1;
        trig_count  <= trig_count + CNT_W'(1);
      end else if ((state == HOLD) && event_saved) begin
        event_valid <= 1'b0;
      end
      if (lost && (lost_count != {CNT_W{1'b1}})) lost_count <= lost_count + CNT_W'(1);
    end
  end
endmodule

// File: doc/multi_event_sampler.md
Name: multi_event_sampler

Overview:
- Parametrised successor to the current fixed 16-channel sampler.
- Continuously samples N_CH channels of SAMP_W bits per clk_500 cycle into per-channel sliding windows of WINDOW samples.
- On a rising trigger edge, captures a frozen event made of PRE pre-trigger samples, the trigger sample and the remaining post-trigger samples. The event is held on evento until downstream acknowledges with event_saved.
- Adds behaviour the current sampler lacks: configurable pre-trigger depth, an explicit valid/ack handshake, an accepted-event counter and a lost-trigger counter.

Parameters:
- N_CH, 16, number of input channels.
- SAMP_W, 2, bits per channel per clock (DDR pair from the input SERDES).
- WINDOW, 32, samples per channel per event; evento width per channel = WINDOW*SAMP_W.
- PRE, 8, samples preceding the trigger sample in the window; legal range 1..WINDOW-1.
- CNT_W, 16, width of trig_count and lost_count.

Ports:
- clk_500  input  1  sample clock, 500 MHz, single clock domain.
- reset  input  1  synchronous, active-low reset.
- Ch  input  [N_CH-1:0][SAMP_W-1:0]  channel samples, one per clock.
- trigger  input  1  trigger level; only rising edges count.
- event_saved  input  1  downstream ack; releases a held event.
- evento  output  [N_CH-1:0][WINDOW*SAMP_W-1:0]  captured event; newest sample in LSBs.
- event_valid  output  1  evento holds a complete, unacknowledged event.
- armed  output  1  block will accept a trigger edge this cycle.
- trig_count  output  CNT_W  accepted events; wraps modulo 2^CNT_W.
- lost_count  output  CNT_W  trigger edges not accepted; saturates at all-ones.

Behaviour:
- Reset (reset==0 at a clk_500 edge) clears:
  - evento, event_valid, armed, trig_count, lost_count, the sliding windows, the trigger delay register and all counters, all to 0;
  - state is set to FILL.
- Sliding window runs every cycle in every state except reset: win[c] <= {win[c][WINDOW*SAMP_W-SAMP_W-1:0], Ch[c]}.
- Edge detect: trig_d <= trigger every cycle, in all states. edge = trigger & ~trig_d. A trigger held high across re-arm never re-fires.
- States:
  - FILL: counts PRE shifted samples after reset, then goes to ARMED. An edge seen in FILL increments lost_count.
  - ARMED (armed=1): on edge, the sample shifted at this edge is the trigger sample. post_cnt <= WINDOW-PRE-1. Goes to POST, or directly to CAPTURE-on-this-edge when WINDOW-PRE-1==0.
  - POST: decrements post_cnt each edge. On the edge where the final post sample shifts in (post_cnt==1), it does all of the following:
    - loads evento[c] <= {win[c][WINDOW*SAMP_W-SAMP_W-1:0], Ch[c]};
    - sets event_valid <= 1;
    - increments trig_count;
    - goes to HOLD.
  - HOLD: evento and event_valid are stable. When event_saved==1: event_valid <= 0 and state goes to ARMED on the next edge. evento retains its last value until the next capture.
  - event_saved outside HOLD is ignored.
- Latency: event_valid is high after the (WINDOW-PRE-1)th edge following the trigger-capture edge; with defaults, 23 edges.
- Window layout: trigger sample sits at sample index WINDOW-PRE-1 counted from the LSB end. For defaults: bits [47:46].
- Lost triggers: an edge in FILL, POST or HOLD increments lost_count (saturating). This includes an edge coinciding with event_saved in HOLD, because armed==0 that cycle.
- armed is a registered output equal to (state==ARMED).
- Reset mid-POST or mid-HOLD discards the event, clears outputs and restarts FILL. No partial event is ever presented.

Test Plan:
- Reset release; Ch idle, trigger=0 -> armed=0 for 8 cycles then armed=1. event_valid=0, counters=0.
- Ch[15]=2'b11 only on the trigger-edge cycle, else 0; one edge while ARMED -> event_valid rises 23 edges later, evento[15]==64'h0000_C000_0000_0000, other channels 0, trig_count=1.
- Ch[c] driven with a per-cycle ramp (sample k = k mod 4) -> every evento[c] equals the 32 consecutive ramp values ending 23 cycles after trigger, newest at bits [1:0].
- Second edge at +5 cycles (POST) and a third during HOLD -> lost_count=2, trig_count=1, evento unchanged. event_saved pulse -> event_valid=0 and armed=1 next cycle.
- trigger held high from before ack through re-arm -> no new event. Subsequent low-then-high -> event accepted, trig_count=2.
- reset=0 pulsed mid-POST -> event_valid stays 0, all outputs 0, armed returns 8 cycles after release. Also run with PRE=31, WINDOW=32 (zero post samples) -> event_valid on the trigger edge itself.
